bus2_line_master: RTL
=====================

BUS2_LINE_MASTER -- requirements
Module: bus2_line_master

Interface
REQ-001 SHALL have parameter ADDR2_BUS_SIZE, default 15, line address width (byte address >> CACHE_OFFSET_SIZE).
REQ-002 SHALL have parameter DATA2_BUS_SIZE, default 16, bus2 data width in bits; DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE/8.
REQ-003 SHALL have parameter CACHE_LINE_SIZE, default 16, line size in bytes; beats N = CACHE_LINE_SIZE/DATA2_BUS_SIZE_BYTES, default 8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256, response wait limit; used only with BUS2_TIMEOUT_EN.
REQ-005 Ports, in order:
- CLK  in  1  clock, all state changes on posedge.
- RESET  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  line request present.
- REQ_READY  out  1  request accepted when REQ_VALID&&REQ_READY.
- REQ_WRITE  in  1  1=write line, 0=read line.
- REQ_ADDR  in  ADDR2_BUS_SIZE  line address.
- REQ_WDATA  in  CACHE_LINE_SIZE*8  write line, byte i at [i*8+:8].
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  CACHE_LINE_SIZE*8  read line, same byte order.
- RSP_ERR  out  1  timeout flag, valid with RSP_VALID.
- A2_OUT  out  ADDR2_BUS_SIZE  bus2 address drive.
- D2_OUT  out  DATA2_BUS_SIZE  bus2 data drive.
- C2_OUT  out  2  bus2 command drive.
- BUS2_OE  out  1  1 = block owns bus2 (tri-state enable for A2/D2/C2).
- D2_IN  in  DATA2_BUS_SIZE  bus2 data sampled.
- C2_IN  in  2  bus2 command sampled.
REQ-006 Bus2 encodings SHALL be C2_NOP=2'd0, C2_RESPONSE=2'd1, C2_READ_LINE=2'd2, C2_WRITE_LINE=2'd3.

Function
REQ-007 FSM states SHALL be IDLE, SEND_WR, SEND_RD, WAIT_RSP, RECV, DONE.
REQ-008 REQ_READY SHALL be 1 only in IDLE; on accept, REQ_ADDR, REQ_WRITE and REQ_WDATA SHALL be latched and the FSM SHALL go to SEND_WR or SEND_RD.
REQ-009 SEND_WR SHALL last exactly N cycles with BUS2_OE=1 and A2_OUT=latched address. C2_OUT=C2_WRITE_LINE on every beat. Beat k D2_OUT = line bytes [k*B..k*B+B-1], byte j on D2_OUT[j*8+:8], B=DATA2_BUS_SIZE_BYTES.
REQ-010 SEND_RD SHALL last exactly 1 cycle, with BUS2_OE=1, C2_OUT=C2_READ_LINE and A2_OUT=latched address.
REQ-011 After the last send cycle, BUS2_OE SHALL be 0 and the FSM SHALL enter WAIT_RSP. D2_IN/C2_IN SHALL NOT be sampled in that same cycle.
REQ-012 In WAIT_RSP, C2_IN==C2_RESPONSE on a posedge SHALL move: write to DONE; read to RECV, capturing that cycle's D2_IN as beat 0. Other C2_IN values SHALL be ignored.
REQ-013 RECV SHALL capture D2_IN on N-1 further consecutive cycles as beats 1..N-1, in REQ-009 byte order, then go to DONE. For N=1, RECV SHALL be skipped.
REQ-014 DONE SHALL last 1 cycle with RSP_VALID=1, then return to IDLE. RSP_RDATA SHALL hold its value until the next read completes; after a write it SHALL be unchanged.
REQ-015 Outside SEND_* states, BUS2_OE=0, C2_OUT=C2_NOP, A2_OUT=0 and D2_OUT=0.
REQ-016 Beat counter width SHALL be $clog2(N)+1. The counter SHALL be reset to 0 on entry to SEND_WR and RECV, with no wrap-around beyond N-1.
REQ-017 REQ_VALID held during a transaction SHALL have no effect; a new request is accepted in the IDLE cycle after DONE at the earliest.

Reset
REQ-018 RESET=1 SHALL immediately force IDLE, regardless of posedge or state, including mid-beat.
REQ-019 RESET=1 SHALL force the following output values: BUS2_OE=0, C2_OUT=C2_NOP, A2_OUT=0, D2_OUT=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, REQ_READY=0.
REQ-020 REQ_READY SHALL become 1 on the first posedge after RESET deasserts; an in-flight transaction SHALL be dropped without RSP_VALID.

Configuration
REQ-021 Macro BUS2_TIMEOUT_EN defined:
- A wait counter SHALL count WAIT_RSP cycles.
- On reaching TIMEOUT_CYCLES without C2_RESPONSE, the FSM SHALL go to DONE with RSP_ERR=1.
- In that case, RSP_RDATA SHALL be unchanged.
REQ-022 Macro BUS2_TIMEOUT_EN undefined: no counter is synthesized, WAIT_RSP waits indefinitely, and RSP_ERR is constant 0.

Verification
REQ-023 Write, ADDR=0x0005, WDATA bytes 0x00..0x0F:
- Expect 8 cycles of C2_WRITE_LINE, A2_OUT=0x0005 and D2_OUT=0x0100, 0x0302, ..., 0x0F0E.
- Responder sends C2_RESPONSE 10 cycles later; expect RSP_VALID 1 cycle after that.
REQ-024 Read, ADDR=0x1234:
- Expect 1 cycle of C2_READ_LINE.
- Responder sends C2_RESPONSE with D2_IN=0xA1A0, then 0xA3A2..0xAFAE on the next 7 cycles.
- Expect RSP_RDATA bytes 0xA0..0xAF and RSP_VALID 1 cycle after the last beat.
REQ-025 C2_IN=C2_RESPONSE on the release cycle right after SEND_WR SHALL be ignored; a second C2_RESPONSE 2 cycles later completes the transaction.
REQ-026 RESET pulse during write beat 3 forces BUS2_OE=0 asynchronously; no RSP_VALID; a following read completes normally.
REQ-027 With BUS2_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read with no response yields RSP_VALID=1, RSP_ERR=1 after 4 WAIT_RSP cycles, with RSP_RDATA unchanged.

Source files
------------

// File: rtl/bus2_line_master.sv
// Cache-line master for bus2: writes a line as N beats or requests a line read and gathers N beats.
// Define BUS2_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES (reported on RSP_ERR).
//   state    | meaning
//   IDLE     | ready for a line request
//   SEND_WR  | driving N write beats
//   SEND_RD  | driving the read-line command
//   WAIT_RSP | bus released, waiting for C2_RESPONSE
//   RECV     | collecting read beats 1..N-1
//   DONE     | one-cycle completion pulse
module bus2_line_master #(
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic                         REQ_WRITE,
    input  logic [ADDR2_BUS_SIZE-1:0]    REQ_ADDR,
    input  logic [CACHE_LINE_SIZE*8-1:0] REQ_WDATA,
    output logic                         RSP_VALID,
    output logic [CACHE_LINE_SIZE*8-1:0] RSP_RDATA,
    output logic                         RSP_ERR,
    output logic [ADDR2_BUS_SIZE-1:0]    A2_OUT,
    output logic [DATA2_BUS_SIZE-1:0]    D2_OUT,
    output logic [1:0]                   C2_OUT,
    output logic                         BUS2_OE,
    input  logic [DATA2_BUS_SIZE-1:0]    D2_IN,
    input  logic [1:0]                   C2_IN
);
    localparam int DATA2_BUS_SIZE_BYTES = DATA2_BUS_SIZE / 8;
    localparam int N      = CACHE_LINE_SIZE / DATA2_BUS_SIZE_BYTES;
    localparam int BEAT_W = $clog2(N) + 1;
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int DW     = DATA2_BUS_SIZE;

    localparam logic [BEAT_W-1:0] LAST_TX = BEAT_W'(N - 1);
    localparam logic [BEAT_W-1:0] LAST_RX = BEAT_W'((N > 1) ? N - 2 : 0);

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_WR  = 3'd1;
    localparam logic [2:0] S_SEND_RD  = 3'd2;
    localparam logic [2:0] S_WAIT_RSP = 3'd3;
    localparam logic [2:0] S_RECV     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]                state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [LINE_W-1:0]         wdata_q, wdata_d;
    logic [LINE_W-1:0]         rbuf_q, rbuf_d;
    logic [LINE_W-1:0]         rdata_q, rdata_d;
    logic                      armed_q, armed_d;
    logic                      live_q;
    logic [DW-1:0]             tx_beat;
    logic [LINE_W-1:0]         rx_line;
    logic                      rsp_seen;
    logic                      sending;

`ifdef BUS2_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    // The release cycle after a send is never sampled; armed_q opens the response window.
    assign rsp_seen = (state_q == S_WAIT_RSP) && armed_q && (C2_IN == C2_RESPONSE);
    assign sending  = (state_q == S_SEND_WR) || (state_q == S_SEND_RD);

    always_comb begin
        tx_beat = '0;
        for (int k = 0; k < N; k++) begin
            if (beat_q == BEAT_W'(k)) begin
                tx_beat = wdata_q[k*DW +: DW];
            end
        end
    end

    // Beat 0 arrives with the response; RECV beat_q=k fills slot k+1.
    always_comb begin
        rx_line = rbuf_q;
        if (state_q == S_WAIT_RSP) begin
            rx_line[0 +: DW] = D2_IN;
        end else begin
            for (int k = 1; k < N; k++) begin
                if (beat_q == BEAT_W'(k - 1)) begin
                    rx_line[k*DW +: DW] = D2_IN;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        armed_d = armed_q;
`ifdef BUS2_TIMEOUT_EN
        wait_d  = wait_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID && live_q) begin
                    addr_d  = REQ_ADDR;
                    write_d = REQ_WRITE;
                    wdata_d = REQ_WDATA;
                    beat_d  = '0;
                    state_d = REQ_WRITE ? S_SEND_WR : S_SEND_RD;
`ifdef BUS2_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_SEND_WR: begin
                if (beat_q == LAST_TX) begin
                    state_d = S_WAIT_RSP;
                    armed_d = 1'b0;
`ifdef BUS2_TIMEOUT_EN
                    wait_d  = WAIT_LOAD;
`endif
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_SEND_RD: begin
                state_d = S_WAIT_RSP;
                armed_d = 1'b0;
`ifdef BUS2_TIMEOUT_EN
                wait_d  = WAIT_LOAD;
`endif
            end
            S_WAIT_RSP: begin
                armed_d = 1'b1;
                if (rsp_seen) begin
                    if (write_q) begin
                        state_d = S_DONE;
                    end else begin
                        rbuf_d = rx_line;
                        if (N == 1) begin
                            rdata_d = rx_line;
                            state_d = S_DONE;
                        end else begin
                            beat_d  = '0;
                            state_d = S_RECV;
                        end
                    end
                end
`ifdef BUS2_TIMEOUT_EN
                else if (wait_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
`endif
            end
            S_RECV: begin
                rbuf_d = rx_line;
                if (beat_q == LAST_RX) begin
                    rdata_d = rx_line;
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            armed_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            armed_q <= armed_d;
            live_q  <= 1'b1;
        end
    end

`ifdef BUS2_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign RSP_ERR = (state_q == S_DONE) && err_q;
`else
    assign RSP_ERR = 1'b0;
`endif

    // Bus drives derive from the state register only, so RESET releases bus2 at once.
    assign REQ_READY = (state_q == S_IDLE) && live_q;
    assign BUS2_OE   = sending;
    assign A2_OUT    = sending ? addr_q : '0;
    assign D2_OUT    = (state_q == S_SEND_WR) ? tx_beat : '0;
    assign C2_OUT    = (state_q == S_SEND_WR) ? C2_WRITE_LINE :
                       (state_q == S_SEND_RD) ? C2_READ_LINE  : C2_NOP;
    assign RSP_VALID = (state_q == S_DONE);
    assign RSP_RDATA = rdata_q;

endmodule
